// File: rtl/td4_program_loader_pkg.sv
// Shared definitions for the TD4 program loader and the TD4 CPU core:
// FSM state encoding, opcode constants and instruction field slices.
package td4_program_loader_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_READY = 2'd1,
        ST_RUN   = 2'd2,
        ST_HALT  = 2'd3
    } td4_state_e;

    localparam int INS_W      = 8;
    localparam int INS_OPC_HI = 7;
    localparam int INS_OPC_LO = 4;
    localparam int INS_IMM_HI = 3;
    localparam int INS_IMM_LO = 0;

    // TD4 opcodes; 4'h0 (ADD A,0) doubles as the no-op used to clear memory.
    localparam logic [3:0] OPC_ADD_A_IM = 4'h0;
    localparam logic [3:0] OPC_MOV_A_B  = 4'h1;
    localparam logic [3:0] OPC_IN_A     = 4'h2;
    localparam logic [3:0] OPC_MOV_A_IM = 4'h3;
    localparam logic [3:0] OPC_MOV_B_A  = 4'h4;
    localparam logic [3:0] OPC_ADD_B_IM = 4'h5;
    localparam logic [3:0] OPC_IN_B     = 4'h6;
    localparam logic [3:0] OPC_MOV_B_IM = 4'h7;
    localparam logic [3:0] OPC_OUT_B    = 4'h9;
    localparam logic [3:0] OPC_OUT_IM   = 4'hB;
    localparam logic [3:0] OPC_JNC_IM   = 4'hE;
    localparam logic [3:0] OPC_JMP_IM   = 4'hF;

    function automatic logic [3:0] ins_opc(input logic [INS_W-1:0] ins);
        return ins[INS_OPC_HI:INS_OPC_LO];
    endfunction

    function automatic logic [3:0] ins_imm(input logic [INS_W-1:0] ins);
        return ins[INS_IMM_HI:INS_IMM_LO];
    endfunction

endpackage

// File: rtl/td4_program_loader_if.sv
// Program byte stream plus the CPU fetch bus. The master drives the byte
// stream and the CPU pc; the slave (loader) returns ready, the fetched
// instruction fields and the execute enable.
interface td4_program_loader_if #(
    parameter int ADDR_W = 4
);
    logic              prog_valid;
    logic              prog_ready;
    logic [7:0]        prog_data;
    logic              prog_last;
    logic [ADDR_W-1:0] pc;
    logic [3:0]        opcode;
    logic [3:0]        immediate;
    logic              exec_mode;

    modport master (
        output prog_valid, prog_data, prog_last, pc,
        input  prog_ready, opcode, immediate, exec_mode
    );

    modport slave (
        input  prog_valid, prog_data, prog_last, pc,
        output prog_ready, opcode, immediate, exec_mode
    );
endinterface

// File: rtl/td4_program_loader_prog_mem.sv
// Program store: 2**ADDR_W words, one synchronous write port, one
// asynchronous read port. Reset clears every word to the no-op 8'h00.
module td4_prog_mem #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port with asynchronous clear of the whole array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/td4_program_loader.sv
// TD4 program loader: accepts a program over a valid/ready byte stream,
// serves opcode/immediate for the CPU pc and paces execution via exec_mode.
// Optional feature: define TD4_STEP_EN to add a single-step input honoured
// in HALT.
module td4_program_loader
    import td4_program_loader_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int EXEC_DIV = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    td4_program_loader_if.slave  bus,
    input  logic                 run_req,
    input  logic                 halt_req,
`ifdef TD4_STEP_EN
    input  logic                 step,
`endif
    output logic [1:0]           state,
    output logic [ADDR_W:0]      prog_count
);
    localparam int PTR_W = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (EXEC_DIV > 1) ? $clog2(EXEC_DIV) : 1;
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_DIV - 1);

    td4_state_e        state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              accept;
    logic              run_fire;
    logic              step_fire;
    logic              enter_load;
    logic              enter_run;
    logic [7:0]        rd_word;

    td4_prog_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (8)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata (bus.prog_data),
        .raddr (bus.pc),
        .rdata (rd_word)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; halt_req takes priority over run_req everywhere.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOAD: begin
                if (accept && (bus.prog_last || wr_ptr_q == PTR_LAST)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY, ST_HALT: begin
                if (halt_req) begin
                    state_d = ST_LOAD;
                end else if (run_req) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // Output logic: stream ready, execute enable and gated instruction fetch.
    always_comb begin
        bus.prog_ready = (state_q == ST_LOAD) && (wr_ptr_q < PTR_FULL);
        accept         = bus.prog_valid && bus.prog_ready;
        run_fire       = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
        bus.exec_mode  = run_fire || step_fire;
        bus.opcode     = '0;
        bus.immediate  = '0;
        if (state_q != ST_LOAD) begin
            bus.opcode    = ins_opc(rd_word);
            bus.immediate = ins_imm(rd_word);
        end
    end

    assign enter_load = (state_q != ST_LOAD) && (state_d == ST_LOAD);
    assign enter_run  = (state_q != ST_RUN)  && (state_d == ST_RUN);

    // Write pointer: advances per accepted byte, rewinds when LOAD is re-entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
        end else if (enter_load) begin
            wr_ptr_q <= '0;
        end else if (accept) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
        end
    end

    // Execution divider: restarts at 0 on every RUN entry, wraps at EXEC_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (enter_run) begin
            cnt_q <= '0;
        end else if (state_q == ST_RUN) begin
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

`ifdef TD4_STEP_EN
    logic step_q;
    logic step_pend_q;

    // Step edge detector: a rising edge seen in HALT yields one pulse next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q      <= 1'b0;
            step_pend_q <= 1'b0;
        end else begin
            step_q      <= step;
            step_pend_q <= (state_q == ST_HALT) && step && !step_q;
        end
    end

    assign step_fire = (state_q == ST_HALT) && step_pend_q;
`else
    assign step_fire = 1'b0;
`endif

    assign state      = state_q;
    assign prog_count = wr_ptr_q;
endmodule
